// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the non-pipelined MIPS core.
// Owns the PC, fetches one word per request over a req/ready handshake,
// holds it for decode under a valid/ack handshake, and applies the
// branch/jump redirect supplied with the ack.
// Optional build macro FETCH_ALIGN_CHECK_EN: adds a sticky misalign output
// and a HALT state entered on a misaligned next PC. Without it, the low two
// bits of every loaded next PC are cleared.
module fetch_unit #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic             misalign_q, misalign_d;
`endif

  // Sequential PC increment; wraps modulo 2^WIDTH.
  assign pc_plus4 = pc_q + PC_STEP;

  // Redirect selection: jump beats a taken branch, otherwise fall through.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Next-state and next-output logic; the instruction word is never inspected.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
`ifdef FETCH_ALIGN_CHECK_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            state_d    = S_REQ;
          end
`else
          pc_d    = next_pc & ALIGN_MASK;
          state_d = S_REQ;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    imem_req_d    = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
  end

  // State and registered outputs; reset aborts any request and drops the held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the non-pipelined MIPS core. It sits directly upstream of decode/control.
- Owns the PC.
- Issues word requests to instruction memory over a req/ready handshake and registers the returned instruction.
- Presents the instruction to decode with a valid/ack handshake.
- Takes the next-PC redirect (beq taken, j) from the consumer on the same ack.

Parameters:
WIDTH, 32, data/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous reset, active-high
imem_req  out  1  request to instruction memory
imem_addr  out  WIDTH  byte address of requested word (= pc)
imem_ready  in  1  memory returns data this cycle; sampled only while imem_req=1
imem_rdata  in  WIDTH  instruction word, valid when imem_ready=1
instr  out  WIDTH  registered instruction to decode
instr_valid  out  1  instr and pc are valid
instr_ack  in  1  decode consumed instr; sampled only while instr_valid=1
branch_taken  in  1  beq resolved taken; sampled with instr_ack
branch_target  in  WIDTH  full branch target address
jump  in  1  j instruction; sampled with instr_ack
jump_index  in  26  instr[25:0] of the j instruction
pc  out  WIDTH  address of the instruction in instr
pc_plus4  out  WIDTH  pc + 4, combinational

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - Outputs: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0; state=IDLE.
  - Asserting reset mid-operation aborts any request: imem_req drops immediately, and any captured instruction is discarded.
- States:
  - IDLE: one cycle after reset deassertion, then -> REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - If imem_ready=1: instr<=imem_rdata, -> HOLD.
    - Otherwise stay; imem_addr stays stable.
  - HOLD: instr_valid=1, imem_req=0.
    - If instr_ack=0: stay; instr and pc stay stable.
    - If instr_ack=1: pc<=next_pc, -> REQ.
- next_pc (evaluated only on ack in HOLD):
  - jump=1: {pc_plus4[31:28], jump_index, 2'b00}.
  - else branch_taken=1: branch_target.
  - else: pc_plus4.
  - jump has priority when jump and branch_taken are asserted together.
- branch_taken and jump are ignored outside HOLD&&instr_ack.
- instr_ack is ignored when instr_valid=0.
- Latency: with imem_ready tied high, instr_valid rises 2 cycles after reset release (IDLE, REQ). Steady state is one instruction per 2 cycles (REQ, HOLD).
- Arithmetic: pc_plus4 is modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Instruction contents are never decoded here. The opcode is opaque, including the bench check opcode 6'b111111.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - If next_pc[1:0]!=0 at ack, misalign is set sticky until reset. The unit then goes to a HALT state: no further requests, instr_valid=0, pc holds the offending address.
- Undefined:
  - No misalign port.
  - next_pc[1:0] is forced to 2'b00 when loaded into pc.

Test Plan:
- Reset/boot: RESET_PC=0, imem_ready=1, instr_ack=1, memory word0=32'h2408_0005 (addiu) -> instr_valid rises 2 cycles after reset release; instr=32'h2408_0005, pc=0; next request addr=4.
- Memory stall: imem_ready low 3 cycles at pc=8 -> imem_req held, imem_addr=8 stable all 3 cycles; instr captured on the 4th cycle.
- Decode stall: instr_ack low 4 cycles in HOLD -> instr, pc, instr_valid constant; no imem_req.
- Redirect: pc=32'h0000_0010, ack with branch_taken=1, target=32'h40 -> next imem_addr=32'h40. Ack with jump=1, jump_index=26'h4, branch_taken=1 -> next imem_addr=32'h10 (jump wins).
- Wrap and reset: pc=32'hFFFF_FFFC, ack with no redirect -> next imem_addr=0. Assert reset while imem_req=1 -> imem_req=0 the same cycle; restart fetches RESET_PC.
- FETCH_ALIGN_CHECK_EN: branch_target=32'h42 -> misalign=1, HALT, pc=32'h42, no imem_req. Without the macro -> imem_addr=32'h40.
